// File: rtl/rd_fetch_pkg.sv
// Shared types and constants for the rd0 frame fetch block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rd_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ADDR  = 2'd2,
    ST_DATA  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/burst_len_calc.sv
// Burst sizing helper: len = min(remaining, BURST_LEN); byte_inc = beats * bytes-per-beat.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
// Ports: remaining (frame beats left), beats (beats to convert to bytes),
//        len (next burst length, 1..BURST_LEN when remaining != 0), byte_inc (address step).
module burst_len_calc #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int BEATS_WIDTH = 20
) (
  input  logic [BEATS_WIDTH-1:0] remaining,
  input  logic [8:0]             beats,
  output logic [8:0]             len,
  output logic [ADDR_WIDTH-1:0]  byte_inc
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  always_comb begin
    if (remaining >= BEATS_WIDTH'(BURST_LEN)) begin
      len = 9'(BURST_LEN);
    end else begin
      // remaining < BURST_LEN <= 256 here, so the narrowing is lossless
      len = 9'(remaining);
    end
  end

  assign byte_inc = ADDR_WIDTH'(beats) << BYTE_SHIFT;

endmodule

// File: rtl/rd0_frame_fetch.sv
// Fetches one frame from DDR via single-outstanding AXI4 INCR read bursts into the rd0 FIFO.
// Latency: start -> m_arvalid 2 cycles; rdata -> fifo_wr_en same cycle; last beat -> done 1 cycle.
// Backpressure: burst issue waits until the FIFO has room for the whole burst; rready is
//               held high in DATA since the room was reserved before the burst was issued.
// Ports: start/base_addr/frame_beats in, busy/done/err status out; FIFO write port
//        (fifo_wr_data/fifo_wr_en out, fifo_wr_level in); AXI AR and R channels (m_*).
module rd0_frame_fetch
  import rd_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH_W = 9,
  parameter int BEATS_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [BEATS_WIDTH-1:0]  frame_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   fifo_wr_data,
  output logic                    fifo_wr_en,
  input  logic [FIFO_DEPTH_W:0]   fifo_wr_level,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int FIFO_WORDS = 1 << FIFO_DEPTH_W;

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEATS_WIDTH-1:0]  remaining_q, remaining_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [8:0]              burst_len;
  logic [ADDR_WIDTH-1:0]   byte_inc;
  logic [8:0]              beats_rcvd;
  logic [FIFO_DEPTH_W+1:0] room_sum;
  logic                    room_ok;
  logic                    beat_take;
  logic                    last_exp;
  logic                    burst_end;

  // Beats received in the current burst, counting the one being taken now; used for the
  // address step so an early rlast still leaves the address at the next unfetched beat.
  assign beats_rcvd = {1'b0, beat_cnt_q} + 9'd1;

  burst_len_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .BEATS_WIDTH(BEATS_WIDTH)
  ) u_len (
    .remaining(remaining_q),
    .beats    (beats_rcvd),
    .len      (burst_len),
    .byte_inc (byte_inc)
  );

  assign room_sum  = (FIFO_DEPTH_W+2)'(fifo_wr_level) + (FIFO_DEPTH_W+2)'(burst_len);
  assign room_ok   = room_sum <= (FIFO_DEPTH_W+2)'(FIFO_WORDS);
  assign beat_take = (state_q == ST_DATA) && m_rvalid;
  assign last_exp  = (beat_cnt_q == arlen_q);
  // A burst ends on rlast or on the expected final beat, whichever comes first.
  assign burst_end = beat_take && (m_rlast || last_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      arlen_q     <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = frame_beats;
          err_d       = 1'b0;
          if (frame_beats == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // Only place the level is looked at: with one burst outstanding, reserving the
        // full burst here is enough to keep the FIFO from overflowing.
        if (room_ok) begin
          arlen_d    = 8'(burst_len - 9'd1);
          beat_cnt_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_take) begin
          remaining_d = remaining_q - BEATS_WIDTH'(1);
          beat_cnt_d  = beat_cnt_q + 8'd1;
          if ((m_rresp != AXI_RESP_OKAY) || (m_rlast != last_exp)) begin
            err_d = 1'b1;
          end
          if (burst_end) begin
            addr_d = addr_q + byte_inc;
            if (remaining_q == BEATS_WIDTH'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    m_arvalid    = (state_q == ST_ADDR);
    m_rready     = (state_q == ST_DATA);
    fifo_wr_en   = beat_take;
    fifo_wr_data = '0;
    if (beat_take) begin
      fifo_wr_data = m_rdata;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_rd0_frame_fetch.sv
// Bench for rd0_frame_fetch: AXI read slave returning address-derived data, FIFO level model,
// and a scoreboard of expected AR requests and FIFO write data filled when each frame starts.
module tb_rd0_frame_fetch;
  localparam int AW = 28, DW = 64, BL = 16, DEPTH_W = 9, BW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, busy, done, err, fifo_wr_en, m_arvalid, m_arready;
  logic m_rlast, m_rvalid, m_rready;
  logic [AW-1:0] base_addr, m_araddr;
  logic [BW-1:0] frame_beats;
  logic [DW-1:0] fifo_wr_data, m_rdata;
  logic [DEPTH_W:0] fifo_wr_level;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst, m_rresp;

  rd0_frame_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_DEPTH_W(DEPTH_W), .BEATS_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .frame_beats(frame_beats),
    .busy(busy), .done(done), .err(err), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_level(fifo_wr_level), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int total = 0, bad = 0;
  logic [35:0] exp_ar_q[$];
  logic [63:0] exp_dat_q[$];
  int done_cnt = 0, ar_cnt = 0;
  int lvl = 0, inc_f = 0, dec_f = 0, cyc = 0, max_lvl = 0;
  bit reader_on = 1'b1, gaps_on = 1'b1;
  bit beat_taken = 1'b0, ar_taken = 1'b0, s_act = 1'b0;
  logic [27:0] s_addr = '0, ar_addr_n = '0;
  int s_len = 0, s_idx = 0, s_bno = 0, ar_len_n = 0;
  int inj_bno = -1, inj_idx = 0, inj_kind = 0;

  function automatic logic [63:0] beat_dat(input logic [27:0] a);
    return {4'h0, a, 4'hA, a ^ 28'h5A5A5A5};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_dat(input logic [27:0] a, input int n);
    for (int i = 0; i < n; i++) exp_dat_q.push_back(beat_dat(a + 28'(i * 8)));
  endtask

  task automatic push_frame(input logic [27:0] a, input int n);
    logic [27:0] p;
    int rem, l;
    p = a;
    rem = n;
    while (rem > 0) begin
      l = (rem > BL) ? BL : rem;
      exp_ar_q.push_back({8'(l - 1), p});
      p = p + 28'(l * 8);
      rem -= l;
    end
    push_dat(a, n);
  endtask

  // AXI slave, FIFO level model and output monitor. Drives on the falling edge, then samples
  // 1 time unit later what the DUT will act on at the coming rising edge.
  initial begin
    m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    fifo_wr_level = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_act = 1'b0; beat_taken = 1'b0; ar_taken = 1'b0; inc_f = 0; dec_f = 0; lvl = 0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
      end else begin
        lvl = lvl + inc_f - dec_f;
        if (lvl > max_lvl) max_lvl = lvl;
        if (beat_taken) s_idx++;
        if (ar_taken) begin
          s_act = 1'b1; s_addr = ar_addr_n; s_len = ar_len_n; s_idx = 0; s_bno++;
        end
        if (s_act && s_idx > s_len) s_act = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        if (s_act && (!gaps_on || $urandom_range(0, 3) != 0)) begin
          if (s_bno == inj_bno && inj_kind == 2 && s_idx == inj_idx) s_len = s_idx;
          m_rvalid = 1'b1;
          m_rdata  = beat_dat(s_addr + 28'(s_idx * 8));
          m_rlast  = (s_idx == s_len);
          if (s_bno == inj_bno && inj_kind == 1 && s_idx == inj_idx) m_rresp = 2'b10;
          if (s_bno == inj_bno && inj_kind == 3 && s_idx == s_len) m_rlast = 1'b0;
        end
      end
      fifo_wr_level = 10'(lvl);
      #1;
      beat_taken = m_rvalid && m_rready;
      ar_taken   = m_arvalid && m_arready;
      if (rst_n) begin
        inc_f = fifo_wr_en ? 1 : 0;
        dec_f = (reader_on && lvl > 0 && (cyc % 4) == 0) ? 1 : 0;
        cyc++;
        if (ar_taken) begin
          ar_addr_n = m_araddr;
          ar_len_n  = int'(m_arlen);
          ar_cnt++;
          chk("ar_room", 64'(lvl + int'(m_arlen) + 1 <= 512), 64'(1));
          if (exp_ar_q.size() == 0) chk("ar_unexp", 64'({m_arlen, m_araddr}), 64'(0));
          else chk("ar_req", 64'({m_arlen, m_araddr}), 64'(exp_ar_q.pop_front()));
        end
        if (fifo_wr_en) begin
          if (exp_dat_q.size() == 0) chk("wr_unexp", fifo_wr_data, 64'(0));
          else chk("wr_dat", fifo_wr_data, exp_dat_q.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [27:0] a, input int n);
    @(negedge clk);
    base_addr = a; frame_beats = 20'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int k;
    k = 0;
    while (done_cnt == d0 && k < limit) begin
      @(negedge clk);
      #2;
      k++;
    end
    idle(10);
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'(1));
    chk({tag, "_ar_left"}, 64'(exp_ar_q.size()), 64'(0));
    chk({tag, "_dat_left"}, 64'(exp_dat_q.size()), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int d0, a0, k;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; frame_beats = '0;
    idle(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst_rready", 64'(m_rready), 64'(0));
    chk("rst_araddr", 64'(m_araddr), 64'(0));
    chk("rst_arsize", 64'(m_arsize), 64'(3));
    chk("rst_arburst", 64'(m_arburst), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: 40 beats from 0x100 -> three bursts, start-to-arvalid latency of 2
    exp_ar_q.push_back({8'd15, 28'h0000100});
    exp_ar_q.push_back({8'd15, 28'h0000180});
    exp_ar_q.push_back({8'd7,  28'h0000200});
    push_dat(28'h100, 40);
    d0 = done_cnt;
    pulse_start(28'h100, 40);
    chk("t1_lat_check", 64'(m_arvalid), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    idle(1);
    chk("t1_lat_addr", 64'(m_arvalid), 64'(1));
    wait_done(d0, 2000, "t1");
    chk("t1_err", 64'(err), 64'(0));

    // 3: zero-beat frame -> done the next cycle, no AR, never busy
    d0 = done_cnt; a0 = ar_cnt;
    pulse_start(28'h300, 0);
    chk("t3_done_pulse", 64'(done), 64'(1));
    chk("t3_busy", 64'(busy), 64'(0));
    idle(1);
    chk("t3_done_clr", 64'(done), 64'(0));
    idle(10);
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'(1));
    chk("t3_no_ar", 64'(ar_cnt - a0), 64'(0));

    // 4: error response on beat 5 of the second burst; then early and late rlast
    inj_kind = 1; inj_idx = 5; inj_bno = s_bno + 2;
    push_frame(28'h1000, 40);
    d0 = done_cnt;
    pulse_start(28'h1000, 40);
    wait_done(d0, 2000, "t4_resp");
    chk("t4_resp_err", 64'(err), 64'(1));
    inj_kind = 2; inj_idx = 4; inj_bno = s_bno + 1;
    exp_ar_q.push_back({8'd15, 28'h0002000});
    exp_ar_q.push_back({8'd14, 28'h0002028});
    push_dat(28'h2000, 20);
    d0 = done_cnt;
    pulse_start(28'h2000, 20);
    chk("t4_err_clr", 64'(err), 64'(0));
    wait_done(d0, 2000, "t4_early");
    chk("t4_early_err", 64'(err), 64'(1));
    inj_kind = 3; inj_bno = s_bno + 1;
    exp_ar_q.push_back({8'd15, 28'h0003000});
    exp_ar_q.push_back({8'd3,  28'h0003080});
    push_dat(28'h3000, 20);
    d0 = done_cnt;
    pulse_start(28'h3000, 20);
    wait_done(d0, 2000, "t4_late");
    chk("t4_late_err", 64'(err), 64'(1));
    inj_kind = 0; inj_bno = -1;

    // 2: 600 beats with the reader stopped -> issue stalls at a full FIFO, then resumes
    k = 0;
    while (lvl > 0 && k < 3000) begin idle(1); k++; end
    reader_on = 1'b0;
    push_frame(28'h10000, 600);
    d0 = done_cnt;
    pulse_start(28'h10000, 600);
    idle(1200);
    chk("t2_stall_lvl", 64'(lvl), 64'(512));
    chk("t2_stall_arvalid", 64'(m_arvalid), 64'(0));
    chk("t2_stall_busy", 64'(busy), 64'(1));
    reader_on = 1'b1;
    wait_done(d0, 6000, "t2");
    chk("t2_max_lvl", 64'(max_lvl <= 512), 64'(1));

    // 5: reset during the second burst, then a clean frame from 0
    a0 = ar_cnt;
    push_frame(28'h500, 40);
    pulse_start(28'h500, 40);
    k = 0;
    while (ar_cnt < a0 + 2 && k < 500) begin idle(1); k++; end
    idle(3);
    chk("t5_in_data", 64'(m_rready), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_rready", 64'(m_rready), 64'(0));
    chk("t5_rst_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("t5_rst_araddr", 64'(m_araddr), 64'(0));
    exp_ar_q.delete();
    exp_dat_q.delete();
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    push_frame(28'h0, 20);
    d0 = done_cnt;
    pulse_start(28'h0, 20);
    wait_done(d0, 2000, "t5");

    // 6: a second start while busy is ignored
    push_frame(28'h6000, 40);
    d0 = done_cnt;
    pulse_start(28'h6000, 40);
    idle(3);
    pulse_start(28'h9000, 7);
    wait_done(d0, 2000, "t6");
    idle(20);
    chk("t6_one_done", 64'(done_cnt - d0), 64'(1));

    // 7: address wraps at 2**28 between bursts
    exp_ar_q.push_back({8'd15, 28'hFFFFFC0});
    exp_ar_q.push_back({8'd15, 28'h0000040});
    push_dat(28'hFFFFFC0, 32);
    d0 = done_cnt;
    pulse_start(28'hFFFFFC0, 32);
    wait_done(d0, 2000, "t7");

    chk("max_lvl", 64'(max_lvl <= 512), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
